multi_clk_gen: RTL
==================

Name: multi_clk_gen

Overview:
- Parametrised multi-channel clock generator running from the 100 MHz board clock.
- Each channel produces a divided clock with near-50% duty and a one-cycle tick at each period start.
- Divisors are runtime-programmable, with glitch-free change at period boundaries, per-channel enable, and a global phase-align input.
- Feeds peripheral interfaces (accelerometer SPI, display refresh, debouncers) that need different rates.

Parameters:
- NUM_CH, 2, number of independent output channels (1..8)
- CNT_W, 8, width of the per-channel counter and divisor
- DIV_RST, 25, divisor loaded into every channel at reset (2 <= DIV_RST < 2^CNT_W)
- EN_RST, 1, reset value of every channel enable bit

Ports:
- ClkPort  input  1  system clock, 100 MHz, all logic on the rising edge
- Reset_n  input  1  asynchronous, active-low reset
- ch_en  input  NUM_CH  per-channel run enable, sampled each edge
- sync_pulse  input  1  restarts all enabled channels in phase
- wr_en  input  1  divisor write strobe, one cycle
- wr_ch  input  3  target channel index
- wr_div  input  CNT_W  new divisor N
- wr_err  output  1  one-cycle pulse flagging a rejected write
- pend  output  NUM_CH  high while a channel's written divisor is not yet active
- clk_out  output  NUM_CH  divided clocks
- tick  output  NUM_CH  one-cycle pulse in the first cycle of each period

Behaviour:
- Decided interface: one clock, ClkPort; Reset_n asynchronous, active-low.
- Reset (Reset_n=0): for each channel, cnt=0, active_div=shadow_div=DIV_RST, and run=EN_RST.
  - Reset values: clk_out=EN_RST, tick=EN_RST, wr_err=0, pend=0.
- Per-channel state: cnt (CNT_W), active_div N, shadow_div, run.
- H = ceil(N/2) = (N+1)>>1.
- clk_out, tick and wr_err are registered; no combinational path from any input.
- In each cycle:
  - clk_out[i] = run[i] & (cnt[i] < H).
  - tick[i] = run[i] & (cnt[i] == 0).
- Period is exactly N cycles: high for H cycles, low for N-H cycles. Example: N=25 gives 13 high, 12 low.
- Count rule while run=1: cnt goes 0..N-1, then wraps to 0. At the wrap edge, active_div <= shadow_div, which clears pend.
- Disable: ch_en[i]=0 sampled at an edge.
  - Next cycle: run=0, cnt=0, clk_out=0, tick=0.
  - Any pending shadow becomes active immediately.
- Enable: ch_en[i] 0->1 sampled at edge E. The cycle after E is cnt=0 with clk_out=1 and tick=1.
- Write: a write is valid if wr_en=1, wr_ch<NUM_CH and wr_div>=2.
  - Valid write: shadow_div[wr_ch] <= wr_div. pend goes high the next cycle unless the value is applied at that same edge.
  - Invalid write: no state change; wr_err=1 for the following cycle.
- Write on the same edge as a wrap: the new value is active for the period that starts at that edge; pend stays 0.
- Write to a disabled channel: takes effect immediately; pend stays 0.
- sync_pulse=1 at an edge: every channel with run=1 (after this edge) sets cnt=0, loads shadow into active, and outputs a tick the next cycle.
- Priority per channel: reset > disable > sync > wrap > increment.
- Repeated writes before a wrap: the last written value wins.
- Reset asserted mid-period: all state returns to reset values immediately (asynchronous). The first edge after release begins counting from cnt=0 to 1.
- Counter compares use CNT_W-bit unsigned arithmetic; no overflow is possible because N <= 2^CNT_W - 1.

Test Plan:
- Reset release, defaults (DIV_RST=25, EN_RST=1) -> both clk_out 13 cycles high / 12 low; tick every 25 cycles, coincident with the clk_out rising edge; 4 MHz period = 250 ns.
- Write ch1 N=4 at mid-period (cnt=7) -> pend[1]=1 until the wrap, then clk_out[1] is 2 high / 2 low and pend[1]=0; ch0 unaffected.
- Write ch0 N=3, then N=5 before the wrap -> next period is 5 cycles with 3 high / 2 low; the value 3 is never observed.
- Write wr_div=1, then wr_ch=5 with NUM_CH=2 -> wr_err pulses 1 cycle each time; divisors and pend unchanged.
- Channels at N=25 and N=10, free-running out of phase; assert sync_pulse -> next cycle both tick=1, cnt=0, clk_out=1; edges aligned.
- Deassert ch_en[0] for 3 cycles, then reassert -> clk_out[0]=0 and tick[0]=0 while disabled; first cycle after re-enable tick=1 and a full 13-cycle high phase.
- Pull Reset_n low mid-high-phase -> outputs take reset values asynchronously.

Source files
------------

// File: rtl/multi_clk_gen.sv
// Multi-channel programmable clock divider.
// Each channel divides ClkPort by a runtime divisor N. Its output is high
// for ceil(N/2) cycles and low for the rest. It also raises a one-cycle
// tick at the start of every period. A new divisor waits in a shadow
// register and becomes active only at a period boundary, on disable, or
// on sync. This keeps every output period whole and glitch-free.

// One divider channel. All outputs are registered and computed from the
// next-state values, so no path runs from an input straight to an output.
module mcg_chan #(
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 25,
    parameter int EN_RST  = 1
) (
    input  logic             ClkPort,
    input  logic             Reset_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    logic [CNT_W-1:0] cnt, active, shadow;
    logic             run;

    logic [CNT_W-1:0] cnt_n, active_n, shadow_n;
    logic             run_n, pend_n, clk_n, tick_n;
    logic [CNT_W:0]   half_n;

    // Next-state selection, highest priority first: disable, (re)start or
    // sync, wrap, then plain increment. Every restart adopts the shadow
    // divisor, and the shadow already includes a write on this same edge.
    always_comb begin
        shadow_n = wr ? wr_div : shadow;
        run_n    = en;
        cnt_n    = cnt + 1'b1;
        active_n = active;
        pend_n   = pend | wr;
        if (!en || !run || sync || (cnt == active - 1'b1)) begin
            cnt_n    = '0;
            active_n = shadow_n;
            pend_n   = 1'b0;
        end
        // H = ceil(N/2), computed one bit wider so that N = 2^CNT_W-1 cannot overflow
        half_n = ({1'b0, active_n} + 1'b1) >> 1;
        clk_n  = run_n & ({1'b0, cnt_n} < half_n);
        tick_n = run_n & (cnt_n == '0);
    end

    // Channel state and registered outputs
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt     <= '0;
            active  <= CNT_W'(DIV_RST);
            shadow  <= CNT_W'(DIV_RST);
            run     <= 1'(EN_RST);
            pend    <= 1'b0;
            clk_out <= 1'(EN_RST);
            tick    <= 1'(EN_RST);
        end else begin
            cnt     <= cnt_n;
            active  <= active_n;
            shadow  <= shadow_n;
            run     <= run_n;
            pend    <= pend_n;
            clk_out <= clk_n;
            tick    <= tick_n;
        end
    end

endmodule

module multi_clk_gen #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 25,
    parameter int EN_RST  = 1
) (
    input  logic              ClkPort,
    input  logic              Reset_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_pulse,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic              wr_err,
    output logic [NUM_CH-1:0] pend,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    // A write needs an existing channel and a divisor of at least 2
    logic wr_ok;
    assign wr_ok = wr_en && (32'(wr_ch) < NUM_CH) && (wr_div >= CNT_W'(2));

    // Rejected writes are flagged for exactly one cycle
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) wr_err <= 1'b0;
        else          wr_err <= wr_en & ~wr_ok;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mcg_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_RST),
            .EN_RST  (EN_RST)
        ) u_ch (
            .ClkPort (ClkPort),
            .Reset_n (Reset_n),
            .en      (ch_en[i]),
            .sync    (sync_pulse),
            .wr      (wr_ok && (wr_ch == 3'(i))),
            .wr_div  (wr_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (pend[i])
        );
    end

endmodule
